// File: rtl/uart_pkg.sv
// Shared definitions for the UART byte-stream bridge: FSM state encodings
// and the fixed 8N1 frame geometry.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_stream_bridge_if.sv
// Ready/valid byte streams between the cpu (master) and the UART bridge (slave).
// Member names follow the bridge's point of view: _i flows into the bridge, _o out of it.
interface uart_stream_bridge_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] in_data_i;
  logic                      in_valid_i;
  logic                      in_ready_o;
  logic [UART_DATA_BITS-1:0] out_data_o;
  logic                      out_valid_o;
  logic                      out_ready_i;

  modport master (
    output in_data_i, in_valid_i, out_ready_i,
    input  in_ready_o, out_data_o, out_valid_o
  );

  modport slave (
    input  in_data_i, in_valid_i, out_ready_i,
    output in_ready_o, out_data_o, out_valid_o
  );

endinterface

// File: rtl/uart_rx_deser.sv
// UART 8N1 deserializer: synchronizes the async line, samples mid-bit and
// reports each good byte with a one-cycle strobe; bad stop bits raise frame_err.
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] rx_byte,
  output logic                      rx_done,
  output logic                      frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]       BIT_LAST = 3'(UART_DATA_BITS - 1);

  logic [SYNC_STAGES-1:0]    sync;
  logic                      rx_s;
  rx_state_t                 state;
  logic [CNT_W-1:0]          cnt;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shift;
  logic                      stop_wait;

  // Synchronizer resets to the idle (high) line level so reset never fakes a start bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sync <= '1;
    else       sync <= {sync[SYNC_STAGES-2:0], rx};
  end

  assign rx_s = sync[SYNC_STAGES-1];

  // Every path back to RX_IDLE leaves rx_s high, so a low level in RX_IDLE is always a fresh falling edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= RX_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      stop_wait <= 1'b0;
      rx_byte   <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (!rx_s) begin
            state <= RX_START;
            cnt   <= '0;
          end
        end
        RX_START: begin
          if (cnt == CNT_HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            shift   <= {rx_s, shift[UART_DATA_BITS-1:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == BIT_LAST) state <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          // After a framing error, linger until the line goes idle before hunting again.
          if (stop_wait) begin
            if (rx_s) begin
              stop_wait <= 1'b0;
              state     <= RX_IDLE;
            end
          end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              rx_byte <= shift;
              rx_done <= 1'b1;
              state   <= RX_IDLE;
            end else begin
              frame_err <= 1'b1;
              stop_wait <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_stream_bridge.sv
// Drop-in replacement for the USB CDC byte streams: cpu bytes go out as 8N1
// on uart_tx_o, received bytes are offered back through a one-deep holding register.
module uart_stream_bridge
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  uart_stream_bridge_if.slave  stream,
  output logic                 uart_tx_o,
  input  logic                 uart_rx_i,
  output logic                 frame_err_o,
  output logic                 overrun_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       BIT_LAST = 3'(UART_DATA_BITS - 1);

  tx_state_t                 tx_state;
  logic [CNT_W-1:0]          tx_cnt;
  logic [2:0]                tx_bit;
  logic [UART_DATA_BITS-1:0] tx_shift;

  logic [UART_DATA_BITS-1:0] rx_byte;
  logic                      rx_done;

  // Transmitter: uart_tx_o is registered and changes on the same edge as the state.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tx_state          <= TX_IDLE;
      tx_cnt            <= '0;
      tx_bit            <= '0;
      tx_shift          <= '0;
      uart_tx_o         <= 1'b1;
      stream.in_ready_o <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (stream.in_valid_i && stream.in_ready_o) begin
            tx_shift          <= stream.in_data_i;
            tx_cnt            <= '0;
            tx_state          <= TX_START;
            uart_tx_o         <= 1'b0;
            stream.in_ready_o <= 1'b0;
          end else begin
            stream.in_ready_o <= 1'b1;
          end
        end
        TX_START: begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_state  <= TX_DATA;
            uart_tx_o <= tx_shift[0];
            tx_shift  <= {1'b0, tx_shift[UART_DATA_BITS-1:1]};
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt <= '0;
            tx_bit <= tx_bit + 3'd1;
            if (tx_bit == BIT_LAST) begin
              tx_state  <= TX_STOP;
              uart_tx_o <= 1'b1;
            end else begin
              uart_tx_o <= tx_shift[0];
              tx_shift  <= {1'b0, tx_shift[UART_DATA_BITS-1:1]};
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt            <= '0;
            tx_state          <= TX_IDLE;
            stream.in_ready_o <= 1'b1;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  uart_rx_deser #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .SYNC_STAGES  (SYNC_STAGES)
  ) u_rx (
    .clk       (clk_i),
    .rstn      (rstn_i),
    .rx        (uart_rx_i),
    .rx_byte   (rx_byte),
    .rx_done   (rx_done),
    .frame_err (frame_err_o)
  );

  // A consume in the completion cycle frees the slot, so the new byte replaces the old without overrun.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      stream.out_data_o  <= '0;
      stream.out_valid_o <= 1'b0;
      overrun_o          <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      if (rx_done) begin
        if (!stream.out_valid_o || stream.out_ready_i) begin
          stream.out_data_o  <= rx_byte;
          stream.out_valid_o <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (stream.out_ready_i) begin
        stream.out_valid_o <= 1'b0;
      end
    end
  end

endmodule
